log2_pipe: RTL and testbench

LOG2_PIPE -- requirements
Module: log2_pipe

---
 rtl/log2_pipe.sv | 170 +++++++++++++++++
 tb/tb_log2_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_pipe.sv
// -----------------------------------------------------------------------------
// log2_pipe
//
// Two-stage valid/ready pipeline that encodes a nominally one-hot operand
// into the index of its highest set bit.
//   Stage 1 registers the accepted operand.
//   Stage 2 registers the encoded result (index, zero flag, error flag).
// Each stage has its own valid bit. A stage advances whenever its downstream
// neighbour can take its contents, so a full pipeline streams one operand per
// cycle while out_ready stays high.
//
// Parameters
//   WIDTH    operand width, 2..64
//   OUT_W    result width, derived as $clog2(WIDTH); do not override
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset; release is expected synchronous
//   in_valid   operand presented on in_data
//   in_ready   pipeline accepts the operand this cycle (combinational from
//              out_ready, independent of in_valid)
//   in_data    operand
//   out_valid  result fields valid
//   out_ready  consumer accepts the result this cycle
//   out_log    index of highest set bit (0 for an all-zero operand)
//   out_zero   operand was all zeros
//   out_err    operand had more than one bit set
//
// Configuration macro
//   LOG2_PIPE_ONEHOT_CHECK_EN  when defined, out_err is computed and
//                              registered with the result; when undefined,
//                              out_err is tied low and no check logic exists.
// -----------------------------------------------------------------------------
module log2_pipe #(
   parameter int WIDTH = 8,
   parameter int OUT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_log,
   output logic             out_zero,
   output logic             out_err
);

   // Stage 1: registered operand
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_data_q,  s1_data_d;

   // Stage 2: registered result
   logic             s2_valid_q, s2_valid_d;
   logic [OUT_W-1:0] s2_log_q,   s2_log_d;
   logic             s2_zero_q,  s2_zero_d;

   logic             s2_load;
   logic             s1_load;

   // Encoder working signals (operate on the stage-1 operand)
   logic [WIDTH-1:0] top_hit;
   logic [OUT_W-1:0] enc_log;
   logic             enc_zero;

   // top_hit[gi] is set only for the highest set bit, so top_hit is one-hot
   // or zero even when the operand has several bits set. That lets the index
   // be formed by OR-ing bit positions without a priority chain.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_top_hit
         assign top_hit[gi] = s1_data_q[gi] & ~(|(s1_data_q >> (gi + 1)));
      end
   endgenerate

   always_comb begin
      enc_log = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (top_hit[i]) begin
            enc_log = enc_log | OUT_W'(i);
         end
      end
   end

   assign enc_zero = ~(|s1_data_q);

   // Handshake: stage 2 frees up when empty or being drained; stage 1 can
   // take a new operand when empty or when its content moves into stage 2.
   always_comb begin
      s2_load  = ~s2_valid_q | out_ready;
      s1_load  = ~s1_valid_q | s2_load;
      in_ready = s1_load;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s2_valid_d = s2_valid_q;
      s2_log_d   = s2_log_q;
      s2_zero_d  = s2_zero_q;

      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         // Result fields only change when a real operand moves in, so the
         // last result stays visible on idle cycles.
         if (s1_valid_q) begin
            s2_log_d  = enc_log;
            s2_zero_d = enc_zero;
         end
      end

      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_log_q   <= '0;
         s2_zero_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s2_valid_q <= s2_valid_d;
         s2_log_q   <= s2_log_d;
         s2_zero_q  <= s2_zero_d;
      end
   end

`ifdef LOG2_PIPE_ONEHOT_CHECK_EN
   // More than one bit set <=> clearing the lowest set bit leaves something.
   // An all-zero operand gives zero here, so out_err and out_zero never
   // assert together.
   logic enc_err;
   logic s2_err_q, s2_err_d;

   assign enc_err = |(s1_data_q & (s1_data_q - {{(WIDTH-1){1'b0}}, 1'b1}));

   always_comb begin
      s2_err_d = s2_err_q;
      if (s2_load && s1_valid_q) begin
         s2_err_d = enc_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_err_q <= 1'b0;
      end else begin
         s2_err_q <= s2_err_d;
      end
   end

   assign out_err = s2_err_q;
`else
   assign out_err = 1'b0;
`endif

   assign out_valid = s2_valid_q;
   assign out_log   = s2_log_q;
   assign out_zero  = s2_zero_q;

endmodule

// File: tb/tb_log2_pipe.sv
// -----------------------------------------------------------------------------
// tb_log2_pipe
//
// Directed bench for log2_pipe. Two instances share clock and reset:
//   u_dut8   WIDTH=8  (streaming, stall, reset, multi-bit operand)
//   u_dut12  WIDTH=12 (non power-of-two width, top and bottom bit)
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. well away from the active edge.
// -----------------------------------------------------------------------------
module tb_log2_pipe;

`ifdef LOG2_PIPE_ONEHOT_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   // WIDTH=8 instance
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out_log;
   logic       out_zero;
   logic       out_err;

   // WIDTH=12 instance
   logic        w12_in_valid = 1'b0;
   logic        w12_in_ready;
   logic [11:0] w12_in_data = '0;
   logic        w12_out_valid;
   logic        w12_out_ready = 1'b1;
   logic [3:0]  w12_out_log;
   logic        w12_out_zero;
   logic        w12_out_err;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   log2_pipe #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_log   (out_log),
      .out_zero  (out_zero),
      .out_err   (out_err)
   );

   log2_pipe #(.WIDTH(12)) u_dut12 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w12_in_valid),
      .in_ready  (w12_in_ready),
      .in_data   (w12_in_data),
      .out_valid (w12_out_valid),
      .out_ready (w12_out_ready),
      .out_log   (w12_out_log),
      .out_zero  (w12_out_zero),
      .out_err   (w12_out_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stream table: zero then one-hot 1..128
   logic [7:0] st_data [9] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                               8'h10, 8'h20, 8'h40, 8'h80};
   logic [2:0] st_log  [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
                               3'd4, 3'd5, 3'd6, 3'd7};
   logic       st_zero [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      logic exp_v;

      // ---------------- reset state ----------------
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_log",   out_log,   0);
      chk("rst_out_zero",  out_zero,  0);
      chk("rst_out_err",   out_err,   0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst12_out_valid", w12_out_valid, 0);
      chk("rst12_in_ready",  w12_in_ready,  1);
      rst_n = 1'b1;
      $display("reset released, idle outputs checked");

      // ---------------- stream 0,1,2,...,128 ----------------
      // First operand is presented right after release and is accepted on
      // the first edge; results appear two edges after presentation.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = st_data[0];
      for (int j = 1; j <= 11; j++) begin
         tick();
         exp_v = (j >= 2) && (j <= 10);
         chk("stream_valid",    out_valid, exp_v);
         chk("stream_in_ready", in_ready,  1);
         if (exp_v) begin
            chk("stream_log",  out_log,  st_log[j-2]);
            chk("stream_zero", out_zero, st_zero[j-2]);
            chk("stream_err",  out_err,  0);
            $display("stream result %0d: in=%02h log=%0d zero=%0d",
                     j - 2, st_data[j-2], out_log, out_zero);
         end
         if (j < 9) begin
            in_data = st_data[j];
         end else begin
            in_valid = 1'b0;
            in_data  = '0;
         end
      end

      // ---------------- multi-bit operand ----------------
      in_valid = 1'b1;
      in_data  = 8'b0010_1000;
      tick();
      in_valid = 1'b0;
      tick();
      chk("multi_valid", out_valid, 1);
      chk("multi_log",   out_log,   5);
      chk("multi_zero",  out_zero,  0);
      chk("multi_err",   out_err,   ERR_EN);
      $display("multi-bit 28: log=%0d err=%0d", out_log, out_err);
      tick();
      chk("multi_drained", out_valid, 0);

      // ---------------- stall with 3 operands offered ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h04;
      #1;
      chk("stall_rdy_a", in_ready, 1);
      tick();                               // A accepted into S1
      in_data = 8'h40;
      #1;
      chk("stall_rdy_b", in_ready, 1);
      tick();                               // A -> S2, B accepted into S1
      in_data = 8'h01;
      #1;
      chk("stall_rdy_c",   in_ready,  0);
      chk("stall_valid0",  out_valid, 1);
      chk("stall_log0",    out_log,   2);
      for (int k = 0; k < 3; k++) begin
         tick();
         // Junk on in_data while blocked must never be captured.
         in_data = (k == 1) ? 8'hFF : 8'h01;
         chk("stall_hold_rdy",   in_ready,  0);
         chk("stall_hold_valid", out_valid, 1);
         chk("stall_hold_log",   out_log,   2);
         chk("stall_hold_zero",  out_zero,  0);
      end
      out_ready = 1'b1;
      #1;
      chk("stall_release_rdy", in_ready, 1);
      tick();                               // A drained, B -> S2, C -> S1
      in_valid = 1'b0;
      chk("stall_out_b_valid", out_valid, 1);
      chk("stall_out_b_log",   out_log,   6);
      $display("stall release: second result log=%0d", out_log);
      tick();
      chk("stall_out_c_valid", out_valid, 1);
      chk("stall_out_c_log",   out_log,   0);
      chk("stall_out_c_zero",  out_zero,  0);
      tick();
      chk("stall_empty", out_valid, 0);

      // ---------------- reset with both stages full ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h10;
      tick();
      in_data = 8'h20;
      tick();
      in_valid = 1'b0;
      chk("rstmid_full_valid", out_valid, 1);
      chk("rstmid_full_log",   out_log,   4);
      chk("rstmid_full_rdy",   in_ready,  0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_valid_drop", out_valid, 0);
      chk("rstmid_log",        out_log,   0);
      chk("rstmid_rdy",        in_ready,  1);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rstmid_no_stale", out_valid, 0);
      end
      $display("mid-operation reset: in-flight operands discarded");

      // ---------------- WIDTH=12 ----------------
      w12_in_valid = 1'b1;
      w12_in_data  = 12'h800;
      tick();
      w12_in_valid = 1'b0;
      tick();
      chk("w12_800_valid", w12_out_valid, 1);
      chk("w12_800_log",   w12_out_log,   11);
      chk("w12_800_zero",  w12_out_zero,  0);
      $display("w12 in=800 log=%0d", w12_out_log);
      tick();
      chk("w12_drained", w12_out_valid, 0);

      w12_in_valid = 1'b1;
      w12_in_data  = 12'h001;
      tick();
      w12_in_data  = 12'h000;
      tick();
      w12_in_valid = 1'b0;
      chk("w12_001_valid", w12_out_valid, 1);
      chk("w12_001_log",   w12_out_log,   0);
      chk("w12_001_zero",  w12_out_zero,  0);
      $display("w12 in=001 log=%0d", w12_out_log);
      tick();
      chk("w12_000_valid", w12_out_valid, 1);
      chk("w12_000_log",   w12_out_log,   0);
      chk("w12_000_zero",  w12_out_zero,  1);
      chk("w12_000_err",   w12_out_err,   0);
      $display("w12 in=000 zero=%0d", w12_out_zero);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
